// File: rtl/id_ex_pipe_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_pipe_pkg
// Shared constants and types for the decode->execute boundary:
//   REG_AW_DEF  default GPR index width
//   DATA_W_DEF  default operand width
//   SA_W        width of the shift-amount field
//   ALUOP_W     width of the ALU operation code
//   aluop_e     ALU operation codes (ALU_NOP = 0 makes the ALU output zero)
// ---------------------------------------------------------------------------
package id_ex_pipe_pkg;

  localparam int REG_AW_DEF = 5;
  localparam int DATA_W_DEF = 32;
  localparam int SA_W       = 5;
  localparam int ALUOP_W    = 8;

  typedef enum logic [ALUOP_W-1:0] {
    ALU_NOP  = 8'h00,
    ALU_ADDU = 8'h01,
    ALU_SUBU = 8'h02,
    ALU_AND  = 8'h03,
    ALU_OR   = 8'h04,
    ALU_XOR  = 8'h05,
    ALU_SLL  = 8'h06,
    ALU_SRL  = 8'h07,
    ALU_SRA  = 8'h08,
    ALU_SLT  = 8'h09
  } aluop_e;

endpackage

// File: rtl/idex_fwd_mux.sv
// ---------------------------------------------------------------------------
// idex_fwd_mux
// Resolves the value of one source register for the instruction in ID and
// reports whether that source cannot be satisfied this cycle.
// Build option: IDEX_FWD_EN
//   defined   -> bypass from EX (non-load) then MEM, stall only on load-use
//   undefined -> regfile value only, stall on any pending EX/MEM writer
// Ports:
//   src_i        source register index        use_i       source is read
//   ex_*_i       EX-stage instruction state   ex_alures_i ALU result in EX
//   mem_*_i      MEM-stage writeback          rf_rdata_i  regfile read data
//   value_o      resolved operand value       hazard_o    source must wait
// Register 0 always reads as zero and never matches a writer.
// ---------------------------------------------------------------------------
module idex_fwd_mux
  import id_ex_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [REG_AW-1:0] src_i,
  input  logic              use_i,
  input  logic              ex_valid_i,
  input  logic              ex_wreg_i,
  input  logic [REG_AW-1:0] ex_wraddr_i,
  input  logic              ex_is_load_i,
  input  logic [DATA_W-1:0] ex_alures_i,
  input  logic              mem_wreg_i,
  input  logic [REG_AW-1:0] mem_wraddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [DATA_W-1:0] rf_rdata_i,
  output logic [DATA_W-1:0] value_o,
  output logic              hazard_o
);

  logic src_zero_s;
  logic ex_hit_s;
  logic mem_hit_s;

  assign src_zero_s = (src_i == {REG_AW{1'b0}});
  assign ex_hit_s   = !src_zero_s && ex_valid_i && ex_wreg_i && (ex_wraddr_i == src_i);
  assign mem_hit_s  = !src_zero_s && mem_wreg_i && (mem_wraddr_i == src_i);

`ifdef IDEX_FWD_EN
  // Operand source: EX result beats MEM value; a load in EX has no data yet.
  always_comb begin
    value_o = rf_rdata_i;
    if (src_zero_s) begin
      value_o = {DATA_W{1'b0}};
    end else if (ex_hit_s && !ex_is_load_i) begin
      value_o = ex_alures_i;
    end else if (mem_hit_s) begin
      value_o = mem_wdata_i;
    end else begin
      value_o = rf_rdata_i;
    end
  end

  // Only a load in EX leaves the operand unavailable.
  assign hazard_o = use_i && ex_hit_s && ex_is_load_i;
`else
  // Without bypassing the regfile is the only source.
  always_comb begin
    value_o = rf_rdata_i;
    if (src_zero_s) begin
      value_o = {DATA_W{1'b0}};
    end else begin
      value_o = rf_rdata_i;
    end
  end

  // Any in-flight writer of this register must drain first.
  assign hazard_o = use_i && (ex_hit_s || mem_hit_s);

  logic unused_s;
  assign unused_s = ^{ex_alures_i, mem_wdata_i, ex_is_load_i};
`endif

endmodule

// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------
// id_ex_pipe
// Decode->execute pipeline register. Selects operands (regfile / immediate /
// shift amount / bypass), latches them with the ALU op and destination into
// EX, and raises a combinational stall request on unresolved RAW hazards.
// Build option: IDEX_FWD_EN enables the EX/MEM bypass network.
// Ports:
//   clk, resetn (sync, active-low), flush, stall_id, stall_ex  control
//   id_*                 decoded instruction in ID
//   rf_rdata1/2          regfile read data for rs / rt
//   ex_alures            ALU result of the instruction in EX
//   mem_wreg/wraddr/wdata  MEM-stage writeback
//   ex_*                 registered EX-stage contents (drive the ALU)
//   stallreq_id          hazard stall request to the pipeline controller
// Update priority per edge: reset > flush > stall_ex hold > stall_id bubble
// > advance. An empty ID slot advances as a bubble.
// ---------------------------------------------------------------------------
module id_ex_pipe
  import id_ex_pipe_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               flush,
  input  logic               stall_id,
  input  logic               stall_ex,
  input  logic               id_valid,
  input  logic [ALUOP_W-1:0] id_aluop,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic               id_use_imm,
  input  logic               id_use_sa,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [SA_W-1:0]    id_sa,
  input  logic               id_wreg,
  input  logic [REG_AW-1:0]  id_wraddr,
  input  logic               id_is_load,
  input  logic [DATA_W-1:0]  rf_rdata1,
  input  logic [DATA_W-1:0]  rf_rdata2,
  input  logic [DATA_W-1:0]  ex_alures,
  input  logic               mem_wreg,
  input  logic [REG_AW-1:0]  mem_wraddr,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_aluop,
  output logic [DATA_W-1:0]  ex_opr1,
  output logic [DATA_W-1:0]  ex_opr2,
  output logic               ex_wreg,
  output logic [REG_AW-1:0]  ex_wraddr,
  output logic               ex_is_load,
  output logic               stallreq_id
);

  logic               ex_valid_q,   ex_valid_d;
  logic [ALUOP_W-1:0] ex_aluop_q,   ex_aluop_d;
  logic [DATA_W-1:0]  ex_opr1_q,    ex_opr1_d;
  logic [DATA_W-1:0]  ex_opr2_q,    ex_opr2_d;
  logic               ex_wreg_q,    ex_wreg_d;
  logic [REG_AW-1:0]  ex_wraddr_q,  ex_wraddr_d;
  logic               ex_is_load_q, ex_is_load_d;

  logic [DATA_W-1:0]  rs_val_s;
  logic [DATA_W-1:0]  rt_val_s;
  logic               rs_hz_s;
  logic               rt_hz_s;
  logic [DATA_W-1:0]  opr1_s;
  logic [DATA_W-1:0]  opr2_s;
  logic               bubble_s;

  idex_fwd_mux #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_fwd_rs (
    .src_i        (id_rs),
    .use_i        (id_use_rs),
    .ex_valid_i   (ex_valid_q),
    .ex_wreg_i    (ex_wreg_q),
    .ex_wraddr_i  (ex_wraddr_q),
    .ex_is_load_i (ex_is_load_q),
    .ex_alures_i  (ex_alures),
    .mem_wreg_i   (mem_wreg),
    .mem_wraddr_i (mem_wraddr),
    .mem_wdata_i  (mem_wdata),
    .rf_rdata_i   (rf_rdata1),
    .value_o      (rs_val_s),
    .hazard_o     (rs_hz_s)
  );

  idex_fwd_mux #(.REG_AW(REG_AW), .DATA_W(DATA_W)) u_fwd_rt (
    .src_i        (id_rt),
    .use_i        (id_use_rt),
    .ex_valid_i   (ex_valid_q),
    .ex_wreg_i    (ex_wreg_q),
    .ex_wraddr_i  (ex_wraddr_q),
    .ex_is_load_i (ex_is_load_q),
    .ex_alures_i  (ex_alures),
    .mem_wreg_i   (mem_wreg),
    .mem_wraddr_i (mem_wraddr),
    .mem_wdata_i  (mem_wdata),
    .rf_rdata_i   (rf_rdata2),
    .value_o      (rt_val_s),
    .hazard_o     (rt_hz_s)
  );

  // Shift-by-immediate puts the zero-extended sa field on opr1.
  assign opr1_s = id_use_sa  ? {{(DATA_W-SA_W){1'b0}}, id_sa} : rs_val_s;
  assign opr2_s = id_use_imm ? id_imm : rt_val_s;

  // A flush always bubbles; otherwise stall_ex holds, even over stall_id.
  assign bubble_s = flush || (!stall_ex && (stall_id || !id_valid));

  assign stallreq_id = id_valid && !flush && (rs_hz_s || rt_hz_s);

  // Next EX-stage contents: bubble, hold, or advance from ID.
  always_comb begin
    ex_valid_d   = ex_valid_q;
    ex_aluop_d   = ex_aluop_q;
    ex_opr1_d    = ex_opr1_q;
    ex_opr2_d    = ex_opr2_q;
    ex_wreg_d    = ex_wreg_q;
    ex_wraddr_d  = ex_wraddr_q;
    ex_is_load_d = ex_is_load_q;
    if (bubble_s) begin
      ex_valid_d   = 1'b0;
      ex_aluop_d   = ALU_NOP;
      ex_opr1_d    = {DATA_W{1'b0}};
      ex_opr2_d    = {DATA_W{1'b0}};
      ex_wreg_d    = 1'b0;
      ex_wraddr_d  = {REG_AW{1'b0}};
      ex_is_load_d = 1'b0;
    end else if (stall_ex) begin
      ex_valid_d   = ex_valid_q;
      ex_aluop_d   = ex_aluop_q;
      ex_opr1_d    = ex_opr1_q;
      ex_opr2_d    = ex_opr2_q;
      ex_wreg_d    = ex_wreg_q;
      ex_wraddr_d  = ex_wraddr_q;
      ex_is_load_d = ex_is_load_q;
    end else begin
      ex_valid_d   = 1'b1;
      ex_aluop_d   = id_aluop;
      ex_opr1_d    = opr1_s;
      ex_opr2_d    = opr2_s;
      ex_wreg_d    = id_wreg;
      ex_wraddr_d  = id_wraddr;
      ex_is_load_d = id_is_load;
    end
  end

  // EX-stage pipeline register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ex_valid_q   <= 1'b0;
      ex_aluop_q   <= {ALUOP_W{1'b0}};
      ex_opr1_q    <= {DATA_W{1'b0}};
      ex_opr2_q    <= {DATA_W{1'b0}};
      ex_wreg_q    <= 1'b0;
      ex_wraddr_q  <= {REG_AW{1'b0}};
      ex_is_load_q <= 1'b0;
    end else begin
      ex_valid_q   <= ex_valid_d;
      ex_aluop_q   <= ex_aluop_d;
      ex_opr1_q    <= ex_opr1_d;
      ex_opr2_q    <= ex_opr2_d;
      ex_wreg_q    <= ex_wreg_d;
      ex_wraddr_q  <= ex_wraddr_d;
      ex_is_load_q <= ex_is_load_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_aluop   = ex_aluop_q;
  assign ex_opr1    = ex_opr1_q;
  assign ex_opr2    = ex_opr2_q;
  assign ex_wreg    = ex_wreg_q;
  assign ex_wraddr  = ex_wraddr_q;
  assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// ---------------------------------------------------------------------------
// tb_id_ex_pipe
// Directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a behavioural model of the EX stage.
// Honours IDEX_FWD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_id_ex_pipe;
  import id_ex_pipe_pkg::*;

  logic        clk;
  logic        resetn, flush, stall_id, stall_ex;
  logic        id_valid;
  logic [7:0]  id_aluop;
  logic [4:0]  id_rs, id_rt;
  logic        id_use_rs, id_use_rt, id_use_imm, id_use_sa;
  logic [31:0] id_imm;
  logic [4:0]  id_sa;
  logic        id_wreg;
  logic [4:0]  id_wraddr;
  logic        id_is_load;
  logic [31:0] rf_rdata1, rf_rdata2, ex_alures;
  logic        mem_wreg;
  logic [4:0]  mem_wraddr;
  logic [31:0] mem_wdata;
  logic        ex_valid;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_opr1, ex_opr2;
  logic        ex_wreg;
  logic [4:0]  ex_wraddr;
  logic        ex_is_load;
  logic        stallreq_id;

  int checks   = 0;
  int failures = 0;

  // Behavioural model of what EX holds.
  logic        m_valid, m_wreg, m_is_load;
  logic [4:0]  m_wraddr;
  logic [7:0]  m_aluop;
  logic [31:0] m_opr1, m_opr2;

  id_ex_pipe dut (
    .clk(clk), .resetn(resetn), .flush(flush), .stall_id(stall_id), .stall_ex(stall_ex),
    .id_valid(id_valid), .id_aluop(id_aluop), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_use_imm(id_use_imm), .id_use_sa(id_use_sa),
    .id_imm(id_imm), .id_sa(id_sa), .id_wreg(id_wreg), .id_wraddr(id_wraddr), .id_is_load(id_is_load),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .ex_alures(ex_alures),
    .mem_wreg(mem_wreg), .mem_wraddr(mem_wraddr), .mem_wdata(mem_wdata),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_opr1(ex_opr1), .ex_opr2(ex_opr2),
    .ex_wreg(ex_wreg), .ex_wraddr(ex_wraddr), .ex_is_load(ex_is_load), .stallreq_id(stallreq_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Value an instruction in ID should see for source r.
  function automatic logic [31:0] m_fwd(input logic [4:0] r, input logic [31:0] rf);
    if (r == 5'd0) return 32'd0;
`ifdef IDEX_FWD_EN
    if (m_valid && m_wreg && !m_is_load && m_wraddr == r) return ex_alures;
    if (mem_wreg && mem_wraddr == r) return mem_wdata;
`endif
    return rf;
  endfunction

  // Whether source r cannot be read this cycle.
  function automatic logic m_hz(input logic used, input logic [4:0] r);
    if (!used || r == 5'd0) return 1'b0;
`ifdef IDEX_FWD_EN
    return m_valid && m_wreg && m_is_load && m_wraddr == r;
`else
    return (m_valid && m_wreg && m_wraddr == r) || (mem_wreg && mem_wraddr == r);
`endif
  endfunction

  function automatic logic m_stall();
    return id_valid && !flush && (m_hz(id_use_rs, id_rs) || m_hz(id_use_rt, id_rt));
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_update();
    logic [31:0] o1, o2;
    o1 = id_use_sa  ? {27'd0, id_sa} : m_fwd(id_rs, rf_rdata1);
    o2 = id_use_imm ? id_imm         : m_fwd(id_rt, rf_rdata2);
    if (!resetn || flush || (!stall_ex && (stall_id || !id_valid))) begin
      m_valid = 1'b0; m_wreg = 1'b0; m_is_load = 1'b0; m_wraddr = 5'd0;
      m_aluop = 8'd0; m_opr1 = 32'd0; m_opr2 = 32'd0;
    end else if (!stall_ex) begin
      m_valid = 1'b1; m_wreg = id_wreg; m_is_load = id_is_load; m_wraddr = id_wraddr;
      m_aluop = id_aluop; m_opr1 = o1; m_opr2 = o2;
    end
  endtask

  task automatic check_outputs();
    chk("ex_valid",   {31'd0, ex_valid},   {31'd0, m_valid});
    chk("ex_aluop",   {24'd0, ex_aluop},   {24'd0, m_aluop});
    chk("ex_opr1",    ex_opr1,             m_opr1);
    chk("ex_opr2",    ex_opr2,             m_opr2);
    chk("ex_wreg",    {31'd0, ex_wreg},    {31'd0, m_wreg});
    chk("ex_wraddr",  {27'd0, ex_wraddr},  {27'd0, m_wraddr});
    chk("ex_is_load", {31'd0, ex_is_load}, {31'd0, m_is_load});
  endtask

  // Called just after a falling edge with inputs driven; ends at the next one.
  task automatic step(input bit pre);
    if (pre) begin
      #1;
      chk("stallreq_id", {31'd0, stallreq_id}, {31'd0, m_stall()});
    end
    @(posedge clk);
    model_update();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic set_idle();
    resetn = 1'b1; flush = 1'b0; stall_id = 1'b0; stall_ex = 1'b0;
    id_valid = 1'b0; id_aluop = ALU_NOP; id_rs = 5'd0; id_rt = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_use_imm = 1'b0; id_use_sa = 1'b0;
    id_imm = 32'd0; id_sa = 5'd0; id_wreg = 1'b0; id_wraddr = 5'd0; id_is_load = 1'b0;
    rf_rdata1 = 32'd0; rf_rdata2 = 32'd0; ex_alures = 32'd0;
    mem_wreg = 1'b0; mem_wraddr = 5'd0; mem_wdata = 32'd0;
  endtask

  initial begin
    m_valid = 1'b0; m_wreg = 1'b0; m_is_load = 1'b0; m_wraddr = 5'd0;
    m_aluop = 8'd0; m_opr1 = 32'd0; m_opr2 = 32'd0;
    set_idle();
    @(negedge clk);

    // 1: reset with a valid instruction presented
    resetn = 1'b0; id_valid = 1'b1; id_aluop = ALU_ADDU; id_rs = 5'd3; id_use_rs = 1'b1;
    rf_rdata1 = 32'd5; id_wreg = 1'b1; id_wraddr = 5'd3;
    step(1'b0);
    chk("t1_valid", {31'd0, ex_valid}, 32'd0);
    chk("t1_aluop", {24'd0, ex_aluop}, 32'd0);
    chk("t1_opr1",  ex_opr1, 32'd0);
    chk("t1_stall", {31'd0, stallreq_id}, 32'd0);

    // 2: plain ADDU r3(5), r4(7) -> r3
    set_idle();
    id_valid = 1'b1; id_aluop = ALU_ADDU; id_rs = 5'd3; id_rt = 5'd4;
    id_use_rs = 1'b1; id_use_rt = 1'b1; rf_rdata1 = 32'd5; rf_rdata2 = 32'd7;
    id_wreg = 1'b1; id_wraddr = 5'd3;
    step(1'b1);
    chk("t2_valid", {31'd0, ex_valid}, 32'd1);
    chk("t2_aluop", {24'd0, ex_aluop}, {24'd0, ALU_ADDU});
    chk("t2_opr1",  ex_opr1, 32'd5);
    chk("t2_opr2",  ex_opr2, 32'd7);

    // 3: ID reads r3 while EX produces r3 = 0x10
    set_idle();
    id_valid = 1'b1; id_aluop = ALU_ADDU; id_rs = 5'd3; id_use_rs = 1'b1;
    rf_rdata1 = 32'd5; ex_alures = 32'h10; id_wreg = 1'b1; id_wraddr = 5'd6;
    #1;
`ifdef IDEX_FWD_EN
    chk("t3_stall", {31'd0, stallreq_id}, 32'd0);
    step(1'b1);
    chk("t3_opr1", ex_opr1, 32'h10);
`else
    chk("t3_stall", {31'd0, stallreq_id}, 32'd1);
    stall_id = 1'b1;
    step(1'b1);
    chk("t3_bubble", {31'd0, ex_valid}, 32'd0);
`endif

    // 4: load -> r5, then a reader of r5
    set_idle();
    id_valid = 1'b1; id_aluop = ALU_ADDU; id_is_load = 1'b1; id_wreg = 1'b1; id_wraddr = 5'd5;
    step(1'b1);
    chk("t4_is_load", {31'd0, ex_is_load}, 32'd1);
    set_idle();
    id_valid = 1'b1; id_aluop = ALU_OR; id_rs = 5'd5; id_use_rs = 1'b1;
    rf_rdata1 = 32'd1; id_wreg = 1'b1; id_wraddr = 5'd7;
    #1;
    chk("t4_stall", {31'd0, stallreq_id}, 32'd1);
    stall_id = 1'b1;
    step(1'b1);
    chk("t4_bubble", {31'd0, ex_valid}, 32'd0);
    stall_id = 1'b0; mem_wreg = 1'b1; mem_wraddr = 5'd5; mem_wdata = 32'hAB;
    #1;
`ifdef IDEX_FWD_EN
    chk("t4_stall2", {31'd0, stallreq_id}, 32'd0);
    step(1'b1);
    chk("t4_opr1", ex_opr1, 32'hAB);
`else
    chk("t4_stall2", {31'd0, stallreq_id}, 32'd1);
    stall_id = 1'b1;
    step(1'b1);
    chk("t4_bubble2", {31'd0, ex_valid}, 32'd0);
`endif

    // 5: SLL sa=31, hold with stall_ex+stall_id, then flush+stall_ex
    set_idle();
    id_valid = 1'b1; id_aluop = ALU_SLL; id_use_sa = 1'b1; id_sa = 5'd31;
    id_wreg = 1'b1; id_wraddr = 5'd8;
    step(1'b1);
    chk("t5_opr1", ex_opr1, 32'h1F);
    set_idle();
    stall_ex = 1'b1; stall_id = 1'b1; id_valid = 1'b1; id_aluop = ALU_ADDU;
    step(1'b1);
    chk("t5_hold_valid", {31'd0, ex_valid}, 32'd1);
    chk("t5_hold_aluop", {24'd0, ex_aluop}, {24'd0, ALU_SLL});
    set_idle();
    flush = 1'b1; stall_ex = 1'b1; id_valid = 1'b1; id_aluop = ALU_ADDU;
    step(1'b1);
    chk("t5_flush", {31'd0, ex_valid}, 32'd0);

    // 6: writer of r0 in EX and MEM, reader of r0 in ID
    set_idle();
    id_valid = 1'b1; id_aluop = ALU_ADDU; id_wreg = 1'b1; id_wraddr = 5'd0;
    step(1'b1);
    set_idle();
    id_valid = 1'b1; id_aluop = ALU_ADDU; id_use_rs = 1'b1; id_use_rt = 1'b1;
    rf_rdata1 = 32'hDEAD; rf_rdata2 = 32'hBEEF; ex_alures = 32'h55;
    mem_wreg = 1'b1; mem_wraddr = 5'd0; mem_wdata = 32'h77;
    #1;
    chk("t6_stall", {31'd0, stallreq_id}, 32'd0);
    step(1'b1);
    chk("t6_opr1", ex_opr1, 32'd0);
    chk("t6_opr2", ex_opr2, 32'd0);

    // Randomized traffic; small register range for frequent collisions.
    for (int i = 0; i < 3000; i++) begin
      resetn     = ($urandom_range(0, 49) != 0);
      flush      = ($urandom_range(0, 15) == 0);
      stall_ex   = ($urandom_range(0, 9) == 0);
      id_valid   = ($urandom_range(0, 4) != 0);
      id_aluop   = 8'($urandom_range(0, 9));
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_use_rs  = 1'($urandom_range(0, 1));
      id_use_rt  = 1'($urandom_range(0, 1));
      id_use_imm = 1'($urandom_range(0, 1));
      id_use_sa  = ($urandom_range(0, 3) == 0);
      id_imm     = $urandom;
      id_sa      = 5'($urandom_range(0, 31));
      id_wreg    = 1'($urandom_range(0, 1));
      id_wraddr  = 5'($urandom_range(0, 3));
      id_is_load = ($urandom_range(0, 3) == 0);
      rf_rdata1  = $urandom;
      rf_rdata2  = $urandom;
      ex_alures  = $urandom;
      mem_wreg   = 1'($urandom_range(0, 1));
      mem_wraddr = 5'($urandom_range(0, 3));
      mem_wdata  = $urandom;
      stall_id   = m_stall() || ($urandom_range(0, 7) == 0);
      step(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
